// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and widths for the execute-stage ALU sequencer.
package alu_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned SHAMT_WIDTH = 3;
  // One extra bit so a shift amount of 0 can be held as a count of 8.
  localparam int unsigned COUNT_WIDTH = SHAMT_WIDTH + 1;

  typedef enum logic [1:0] {
    ALU_SHR = 2'b00,
    ALU_SHL = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  typedef struct packed {
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  flag_we;
  } alu_req_t;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SHR) || (op == ALU_SHL);
  endfunction

  // Shift amount 0 encodes a full-width shift.
  function automatic logic [COUNT_WIDTH-1:0] shift_count(input logic [SHAMT_WIDTH-1:0] shamt);
    return (shamt == '0) ? COUNT_WIDTH'(DATA_WIDTH) : COUNT_WIDTH'(shamt);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Execute-stage controller: sequences one op through the 8-bit ALU (multi-bit
// shifts as repeated single-bit shifts) and returns result/flags on a response port.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  req_flag_we,
  output logic [1:0]            alu_select,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  output logic                  flag_we,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic                  rsp_negative,
  output logic                  busy
);

  seq_state_e             state_q, state_d;
  alu_req_t               req_q;
  logic [DATA_WIDTH-1:0]  work_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   accept;
  logic                   capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ALU/handshake drive
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy       = 1'b1;
    alu_select = ALU_SHR;
    alu_a      = '0;
    alu_b      = '0;
    flag_we    = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = is_shift(alu_op_e'(req_op)) ? ST_SHIFT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_select = req_q.op;
        alu_a      = req_q.a;
        alu_b      = req_q.b;
        flag_we    = req_q.flag_we;
        capture    = 1'b1;
        state_d    = ST_DONE;
      end
      ST_SHIFT: begin
        alu_select = req_q.op;
        alu_a      = work_q;
        // Only the final single-bit shift updates the flag register.
        if (count_q == COUNT_WIDTH'(1)) begin
          flag_we = req_q.flag_we;
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, shift working register and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      work_q       <= '0;
      count_q      <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      rsp_valid <= (state_d == ST_DONE);
      if (accept) begin
        req_q   <= '{op: alu_op_e'(req_op), a: req_a, b: req_b, flag_we: req_flag_we};
        work_q  <= req_a;
        count_q <= shift_count(req_b[SHAMT_WIDTH-1:0]);
      end
      if (state_q == ST_SHIFT) begin
        work_q  <= alu_result;
        count_q <= count_q - COUNT_WIDTH'(1);
      end
      // Shifts never report overflow; carry is the last bit shifted out.
      if (capture) begin
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carry;
        rsp_overflow <= (state_q == ST_EXEC) ? alu_overflow : 1'b0;
        rsp_zero     <= alu_zero;
        rsp_negative <= alu_negative;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Execute-stage controller that sits directly upstream of the 8-bit ALU and the flag register. It accepts one operation per valid/ready handshake, registers the operands, and drives the ALU select and operand inputs. Multi-bit shifts run as repeated single-bit ALU shifts. It pulses the flag-register write enable on the final ALU cycle, then returns the result and flags on a valid/ready response port.

Parameters:
DATA_WIDTH, 8, operand/result width; the ALU is fixed at 8, so no other value is supported.
SHAMT_WIDTH, 3, width of the shift-amount field taken from req_b[SHAMT_WIDTH-1:0].

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_op  in  2  00 SHR, 01 SHL, 10 ADD, 11 SUB
req_a  in  8  operand A / shift source
req_b  in  8  operand B; for shifts, bits [2:0] = shift amount
req_flag_we  in  1  update flag register for this op
alu_select  out  2  to ALU select
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_result  in  8  from ALU
alu_carry, alu_overflow, alu_zero, alu_negative  in  1 each  from ALU
flag_we  out  1  to flag register write_enable
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  8  registered result
rsp_carry, rsp_overflow, rsp_zero, rsp_negative  out  1 each  registered flags
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. On reset:
  - state = IDLE; all rsp_* = 0; flag_we = 0; alu_* = 0.
  - Any in-flight op is discarded with no flag write.
- FSM states: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture op, A, B and req_flag_we.
  - ADD/SUB goes to EXEC.
  - SHR/SHL loads the working register with A and count with req_b[2:0], where 0 means 8, then goes to SHIFT.
- EXEC (exactly 1 cycle):
  - Drive alu_select = op, alu_a = A, alu_b = B; flag_we = captured req_flag_we.
  - At the edge: register alu_result and the four flags into rsp_*, then go to DONE.
- SHIFT (count cycles):
  - Drive alu_select = op, alu_a = working register, alu_b = 0.
  - Each edge: working <= alu_result, count <= count-1.
  - When count == 1: flag_we = captured req_flag_we during that cycle only. At the edge, capture result and flags into rsp_* and go to DONE.
  - The carry reported is the last bit shifted out; overflow is 0.
- DONE:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. One bubble cycle exists before the next accept.
- Outputs outside EXEC/SHIFT: alu_select = 00, alu_a = alu_b = 0, flag_we = 0.
- flag_we is combinational from state/count and is never high for more than 1 cycle per op.
- req_ready = 0 in EXEC, SHIFT and DONE; req_valid there is ignored and not queued.
- Latency (accept edge to rsp_valid): ADD/SUB = 2 cycles; shift by n = n+1 cycles (shift by 8 = 9).
- Arithmetic is the ALU's. SUB carry = 1 means no borrow. ADD/SUB overflow = signed overflow.
- Reset asserted mid-SHIFT or mid-DONE aborts the op immediately. A fresh request is accepted on the first edge after rst_n rises.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings ALU_SHR=2'b00, ALU_SHL=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11;
  - the FSM state enum;
  - DATA_WIDTH/SHAMT_WIDTH constants.
- Single module, no sub-module. The ALU and flag_register are instantiated alongside it in the execute-stage top, not inside it.

Test Plan:
- ADD 0x7F+0x01, req_flag_we=1 -> flag_we high in cycle 1 only; rsp_valid in cycle 2; result 0x80, C0 V1 Z0 N1; flag register holds the same.
- SUB 0x05-0x05 -> result 0x00, C1 V0 Z1 N0; latency 2.
- SHL 0xB5 by 3 -> intermediate values 0x6A, 0xD4, then 0xA8; final C1 V0 Z0 N1; flag_we only in 3rd SHIFT cycle; rsp_valid 4 cycles after accept.
- SHR 0x80 with req_b[2:0]=0 (8 shifts) -> result 0x00, C1 Z1 N0 V0; latency 9.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 and a different op -> rsp_* stable, req_ready=0, second op not accepted until after the response handshake. With req_flag_we=0, flag_we never rises.
- Assert rst_n=0 during the 2nd cycle of an 8-step shift -> state IDLE, rsp_valid=0, flag_we=0, flag register cleared. After release, ADD 0x0F+0x01 -> 0x10, C0 V0 Z0 N0.
